sram_1r1w_param: RTL

- Parametrised single-clock memory with one write port and one read port.
- Successor to the fixed 19x256 L1 array. Adds:
  - generic width and depth
  - per-lane write mask
  - selectable 1- or 2-cycle read latency
  - rd_valid handshake
  - a hardware flush sequencer that zeroes every entry
- Backs the L1 tag/valid and data arrays. Later cache sizes reuse the same block.

---
 rtl/sram_1r1w_param_pkg.sv | 27 ++
 rtl/sram_1r1w_param_if.sv | 31 +++
 rtl/sram_1r1w_param_flush_seq.sv | 58 +++++
 rtl/sram_1r1w_param.sv | 132 +++++++++++++
 4 files changed

// File: rtl/sram_1r1w_param_pkg.sv
// Shared types and helpers for the parametrised 1R1W SRAM block.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sram_pkg;

  // Deepest read pipeline the block supports (array stage + output stage).
  localparam int READ_LAT_MAX = 2;

  // Widest word lane_merge can handle; callers cast to/from this width.
  localparam int SRAM_MAX_W = 1024;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  // Bitwise merge: bits set in bit_mask come from new_w, the rest from old_w.
  // The caller expands the per-lane write mask to a per-bit mask first.
  function automatic logic [SRAM_MAX_W-1:0] lane_merge(
    input logic [SRAM_MAX_W-1:0] old_w,
    input logic [SRAM_MAX_W-1:0] new_w,
    input logic [SRAM_MAX_W-1:0] bit_mask
  );
    return (old_w & ~bit_mask) | (new_w & bit_mask);
  endfunction

endpackage

// File: rtl/sram_1r1w_param_if.sv
// Request/response bundle between a client and the 1R1W SRAM.
// Latency: n/a (wires only).
// Backpressure: none; flush_busy tells the client its requests are being dropped.
interface sram_1r1w_param_if #(
  parameter int DATA_WIDTH = 19,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_LANES  = 1
);
  logic                  flush_req;
  logic                  flush_busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_LANES-1:0]  wr_mask;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  // Client side: issues reads, writes and flushes.
  modport master (
    output flush_req, wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
    input  flush_busy, rd_data, rd_valid
  );

  // Memory side.
  modport slave (
    input  flush_req, wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
    output flush_busy, rd_data, rd_valid
  );
endinterface

// File: rtl/sram_1r1w_param_flush_seq.sv
// Flush sequencer: sweeps every array entry once, writing zero, after reset or flush_req.
// Latency: flush_busy rises the cycle after flush_req/reset and stays high exactly DEPTH cycles.
// Backpressure: none; flush_req during a sweep is ignored, reset restarts the sweep at entry 0.
module sram_flush_seq
  import sram_pkg::*;
#(
  parameter  int DEPTH      = 256,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req_i,
  output logic                  flush_busy_o,
  output logic                  flush_we_o,
  output logic [ADDR_WIDTH-1:0] flush_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  flush_state_e          state_q;
  logic [ADDR_WIDTH-1:0] flush_cnt_q;
  logic                  flush_busy_q;

  // FSM: reset lands in FLUSH so the array is cleared before first use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FLUSH;
      flush_cnt_q  <= '0;
      flush_busy_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_req_i) begin
            state_q      <= FLUSH;
            flush_cnt_q  <= '0;
            flush_busy_q <= 1'b1;
          end
        end
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q + ADDR_WIDTH'(1);
          if (flush_cnt_q == LAST_ADDR) begin
            state_q      <= IDLE;
            flush_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          flush_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush_busy_o = flush_busy_q;
  assign flush_we_o   = flush_busy_q;
  assign flush_addr_o = flush_cnt_q;

endmodule

// File: rtl/sram_1r1w_param.sv
// Parametrised single-clock 1R1W memory with lane write mask, hardware flush and optional RAW bypass (SRAM_RAW_BYPASS_EN).
// Latency: read data/rd_valid READ_LAT (1 or 2) cycles after rd_en; writes visible to reads in the next cycle.
// Backpressure: none; wr_en/rd_en are dropped while flush_busy is high, in-flight reads still complete.
module sram_1r1w_param
  import sram_pkg::*;
#(
  parameter  int DATA_WIDTH = 19,
  parameter  int DEPTH      = 256,
  parameter  int LANE_WIDTH = DATA_WIDTH,
  parameter  int READ_LAT   = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int NUM_LANES  = DATA_WIDTH / LANE_WIDTH
) (
  input logic               clk,
  input logic               rst,
  sram_1r1w_param_if.slave  bus
);

  // Elaboration-time sanity checks on the configuration.
  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_chk_lane
    $warning("sram_1r1w_param: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (READ_LAT < 1 || READ_LAT > READ_LAT_MAX) begin : g_chk_lat
    $warning("sram_1r1w_param: READ_LAT must be 1 or 2");
  end
  if (DATA_WIDTH > SRAM_MAX_W) begin : g_chk_width
    $warning("sram_1r1w_param: DATA_WIDTH exceeds lane_merge width");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  flush_busy;
  logic                  flush_we;
  logic [ADDR_WIDTH-1:0] flush_addr;

  sram_flush_seq #(
    .DEPTH (DEPTH)
  ) u_flush_seq (
    .clk          (clk),
    .rst          (rst),
    .flush_req_i  (bus.flush_req),
    .flush_busy_o (flush_busy),
    .flush_we_o   (flush_we),
    .flush_addr_o (flush_addr)
  );

  assign bus.flush_busy = flush_busy;

  logic wr_acc;
  logic rd_acc;
  assign wr_acc = bus.wr_en & ~flush_busy;
  assign rd_acc = bus.rd_en & ~flush_busy;

  logic [DATA_WIDTH-1:0] wr_bit_mask;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  // Expand the lane mask to a bit mask and merge with the stored word.
  always_comb begin
    wr_bit_mask = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      wr_bit_mask[l*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{bus.wr_mask[l]}};
    end
    wr_merged = DATA_WIDTH'(lane_merge(SRAM_MAX_W'(mem_q[bus.wr_addr]),
                                       SRAM_MAX_W'(bus.wr_data),
                                       SRAM_MAX_W'(wr_bit_mask)));
  end

  // Stage-1 read word; the bypass forwards a same-cycle write to the same address.
`ifdef SRAM_RAW_BYPASS_EN
  always_comb begin
    rd_word = mem_q[bus.rd_addr];
    if (wr_acc && (bus.wr_addr == bus.rd_addr)) begin
      rd_word = wr_merged;
    end
  end
`else
  always_comb begin
    rd_word = mem_q[bus.rd_addr];
  end
`endif

  // Array write port; the flush sweep owns the port while it runs.
  always_ff @(posedge clk) begin
    if (flush_we) begin
      mem_q[flush_addr] <= '0;
    end else if (wr_acc) begin
      mem_q[bus.wr_addr] <= wr_merged;
    end
  end

  logic                  rd_s1_vld_q;
  logic [DATA_WIDTH-1:0] rd_s1_dat_q;

  // Read stage 1: array output register, holds data between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_s1_vld_q <= 1'b0;
      rd_s1_dat_q <= '0;
    end else begin
      rd_s1_vld_q <= rd_acc;
      if (rd_acc) begin
        rd_s1_dat_q <= rd_word;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic                  rd_s2_vld_q;
    logic [DATA_WIDTH-1:0] rd_s2_dat_q;

    // Read stage 2: extra output register for timing-critical placements.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_s2_vld_q <= 1'b0;
        rd_s2_dat_q <= '0;
      end else begin
        rd_s2_vld_q <= rd_s1_vld_q;
        if (rd_s1_vld_q) begin
          rd_s2_dat_q <= rd_s1_dat_q;
        end
      end
    end

    assign bus.rd_valid = rd_s2_vld_q;
    assign bus.rd_data  = rd_s2_dat_q;
  end else begin : g_lat1
    assign bus.rd_valid = rd_s1_vld_q;
    assign bus.rd_data  = rd_s1_dat_q;
  end

endmodule
